// File: rtl/gvt_collector_pkg.sv
// Shared chronos types for virtual-time handling: VT layout, epoch tag,
// idle-tile sentinel and the GVT collector's round states.
package chronos;

  localparam int unsigned DEFAULT_N_TILES        = 14;
  localparam int unsigned DEFAULT_TS_WIDTH       = 32;
  localparam int unsigned DEFAULT_TB_WIDTH       = 32;
  localparam int unsigned DEFAULT_EPOCH_WIDTH    = 8;
  localparam int unsigned DEFAULT_LOG_GVT_PERIOD = 5;

  localparam int unsigned VT_WIDTH = DEFAULT_TS_WIDTH + DEFAULT_TB_WIDTH;

  typedef logic [DEFAULT_TS_WIDTH-1:0]    ts_t;
  typedef logic [DEFAULT_TB_WIDTH-1:0]    tb_t;
  typedef logic [DEFAULT_EPOCH_WIDTH-1:0] epoch_t;

  typedef struct packed {
    ts_t ts;
    tb_t tb;
  } vt_t;

  // An idle tile reports the largest representable VT.
  localparam vt_t VT_INFINITY = '1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    COLLECT,
    REDUCE,
    PUBLISH
  } gvt_state_e;

endpackage

// File: rtl/gvt_collector_min_tree.sv
// Pipelined N-input unsigned minimum: one register stage per tree level,
// unused leaves padded with the all-ones (infinity) VT.
module vt_min_tree #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 64
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N*W-1:0] in_vts,
  output logic [W-1:0]   min_vt
);

  localparam int unsigned L      = (N <= 1) ? 0 : $clog2(N);
  localparam int unsigned LEAVES = 1 << L;

  if (L == 0) begin : g_pass
    always_comb min_vt = in_vts[W-1:0];
  end else begin : g_tree
    logic [LEAVES*W-1:0] padded;
    logic [W-1:0]        node [1:LEAVES-1];
    logic [W-1:0]        heap [1:2*LEAVES-1];

    always_comb begin
      padded            = '1;
      padded[N*W-1:0]   = in_vts;
    end

    // Heap layout: index k has children 2k and 2k+1; leaves sit at LEAVES..2*LEAVES-1.
    always_comb begin
      for (int unsigned k = 1; k < LEAVES; k++)
        heap[k] = node[k];
      for (int unsigned k = LEAVES; k < 2*LEAVES; k++)
        heap[k] = padded[(k-LEAVES)*W +: W];
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int unsigned k = 1; k < LEAVES; k++)
          node[k] <= '1;
      end else begin
        for (int unsigned k = 1; k < LEAVES; k++)
          node[k] <= (heap[2*k+1] < heap[2*k]) ? heap[2*k+1] : heap[2*k];
      end
    end

    always_comb min_vt = heap[1];
  end

endmodule

// File: rtl/gvt_collector.sv
// Global-virtual-time collector: polls every tile for its local minimum VT
// once per period, reduces the tagged replies and publishes a monotonic GVT.
module gvt_collector
  import chronos::*;
#(
  parameter int unsigned N_TILES        = DEFAULT_N_TILES,
  parameter int unsigned TS_WIDTH       = DEFAULT_TS_WIDTH,
  parameter int unsigned TB_WIDTH       = DEFAULT_TB_WIDTH,
  parameter int unsigned EPOCH_WIDTH    = DEFAULT_EPOCH_WIDTH,
  parameter int unsigned LOG_GVT_PERIOD = DEFAULT_LOG_GVT_PERIOD
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     gvt_enable,
  output logic                                     lvt_req,
  output logic [EPOCH_WIDTH-1:0]                   lvt_req_epoch,
  input  logic [N_TILES-1:0]                       lvt_valid,
  input  logic [N_TILES*EPOCH_WIDTH-1:0]           lvt_epoch,
  input  logic [N_TILES*(TS_WIDTH+TB_WIDTH)-1:0]   lvt,
  output logic                                     gvt_valid,
  output logic [TS_WIDTH+TB_WIDTH-1:0]             gvt,
  output logic                                     gvt_regress
);

  localparam int unsigned VTW = TS_WIDTH + TB_WIDTH;
  localparam int unsigned L   = (N_TILES <= 1) ? 0 : $clog2(N_TILES);
  localparam int unsigned RCW = (L > 1) ? $clog2(L) : 1;

  gvt_state_e                  state;
  logic [LOG_GVT_PERIOD-1:0]   period_cnt;
  logic                        period_end;
  logic                        pending;
  logic [EPOCH_WIDTH-1:0]      epoch;
  logic [N_TILES-1:0]          received;
  logic [N_TILES-1:0]          accept;
  logic [N_TILES*VTW-1:0]      captured;
  logic [RCW-1:0]              red_cnt;
  logic [VTW-1:0]              min_vt;

  always_comb period_end    = (period_cnt == '1);
  always_comb lvt_req_epoch = epoch;

  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_TILES; i++)
      accept[i] = (state == COLLECT) && lvt_valid[i] && !received[i] &&
                  (lvt_epoch[i*EPOCH_WIDTH +: EPOCH_WIDTH] == epoch);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) period_cnt <= '0;
    else       period_cnt <= period_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      captured <= '0;
    end else begin
      for (int unsigned i = 0; i < N_TILES; i++)
        if (accept[i]) captured[i*VTW +: VTW] <= lvt[i*VTW +: VTW];
    end
  end

  vt_min_tree #(
    .N (N_TILES),
    .W (VTW)
  ) u_min_tree (
    .clk    (clk),
    .rstn   (rstn),
    .in_vts (captured),
    .min_vt (min_vt)
  );

  // gvt_valid/gvt are registered on the edge leaving PUBLISH, so the pulse
  // lands L+2 cycles after the last accepted reply for every tree depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pending     <= 1'b0;
      epoch       <= '0;
      received    <= '0;
      red_cnt     <= '0;
      lvt_req     <= 1'b0;
      gvt_valid   <= 1'b0;
      gvt         <= '0;
      gvt_regress <= 1'b0;
    end else begin
      lvt_req   <= 1'b0;
      gvt_valid <= 1'b0;
      if (state != IDLE && period_end && gvt_enable) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (!gvt_enable) begin
            pending <= 1'b0;
          end else if (pending || period_end) begin
            state   <= REQ;
            lvt_req <= 1'b1;
            pending <= 1'b0;
          end
        end
        REQ: begin
          received <= '0;
          state    <= COLLECT;
        end
        COLLECT: begin
          received <= received | accept;
          if (&received) begin
            red_cnt <= '0;
            state   <= (L == 0) ? PUBLISH : REDUCE;
          end
        end
        REDUCE: begin
          if (red_cnt == RCW'(L - 1)) state <= PUBLISH;
          else                        red_cnt <= red_cnt + 1'b1;
        end
        PUBLISH: begin
          gvt_valid <= 1'b1;
          epoch     <= epoch + 1'b1;
          state     <= IDLE;
          if (min_vt >= gvt) gvt <= min_vt;
          else               gvt_regress <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gvt_collector.sv
// Randomized scoreboard bench for gvt_collector: a driver plays tile replies
// per round, a monitor checks every GVT publish against the queued expectation.
module tb_gvt_collector;
  import chronos::*;

  localparam int unsigned NT  = 14;
  localparam int unsigned EW  = 8;
  localparam int unsigned VW  = VT_WIDTH;
  localparam int          LAT = 6;
  localparam int          PER = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              gvt_enable = 1'b0;
  logic              lvt_req;
  logic [EW-1:0]     lvt_req_epoch;
  logic [NT-1:0]     lvt_valid = '0;
  logic [NT*EW-1:0]  lvt_epoch = '0;
  logic [NT*VW-1:0]  lvt = '0;
  logic              gvt_valid;
  logic [VW-1:0]     gvt;
  logic              gvt_regress;

  always #5 clk = ~clk;

  gvt_collector #(
    .N_TILES        (NT),
    .TS_WIDTH       (32),
    .TB_WIDTH       (32),
    .EPOCH_WIDTH    (EW),
    .LOG_GVT_PERIOD (5)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .gvt_enable    (gvt_enable),
    .lvt_req       (lvt_req),
    .lvt_req_epoch (lvt_req_epoch),
    .lvt_valid     (lvt_valid),
    .lvt_epoch     (lvt_epoch),
    .lvt           (lvt),
    .gvt_valid     (gvt_valid),
    .gvt           (gvt),
    .gvt_regress   (gvt_regress)
  );

  typedef struct {
    logic [VW-1:0] gvt;
    logic          regress;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  bit            dead = 0;

  logic [VW-1:0] m_gvt;
  logic          m_regress;
  int            m_epoch;
  int            exp_req;
  int            req_cyc;
  logic [VW-1:0] r_val [NT];
  int            r_acc [NT];

  // Cycle index after each edge since reset release; first edge yields 1.
  always @(posedge clk) cyc = rstn ? cyc + 1 : 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gvt_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_gvt_valid", VW'(gvt_valid), '0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("gvt", gvt, e.gvt);
          check("gvt_regress", VW'(gvt_regress), VW'(e.regress));
          check("gvt_latency", VW'(cyc), VW'(e.due));
        end
      end
    end
  end

  task automatic model_reset();
    m_gvt     = '0;
    m_regress = 1'b0;
    m_epoch   = 0;
    exp_req   = PER;
  endtask

  task automatic put(input int i, input logic [EW-1:0] ep, input logic [VW-1:0] v);
    lvt_valid[i]          = 1'b1;
    lvt_epoch[i*EW +: EW] = ep;
    lvt[i*VW +: VW]       = v;
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (lvt_req !== 1'b1 && n < 300);
    if (lvt_req !== 1'b1) begin
      check("lvt_req_timeout", VW'(lvt_req), VW'(1));
      dead = 1;
    end else begin
      req_cyc = cyc;
      check("lvt_req_cycle", VW'(cyc), VW'(exp_req));
      check("lvt_req_epoch", VW'(lvt_req_epoch), VW'(m_epoch));
    end
  endtask

  // Cycle c=0 is the request cycle; a value driven in cycle c is sampled at the next edge.
  task automatic drive_round(input bit noise, input bit filt);
    int            amax = 0;
    int            nb;
    logic [VW-1:0] mn = '1;
    logic [EW-1:0] good, stale;
    exp_t          e;
    good  = EW'(m_epoch);
    for (int i = 0; i < NT; i++) begin
      if (r_acc[i] > amax) amax = r_acc[i];
      if (r_val[i] < mn)   mn = r_val[i];
    end
    for (int c = 0; c <= amax + 2; c++) begin
      lvt_valid = '0;
      for (int i = 0; i < NT; i++) begin
        stale = good + EW'($urandom_range(1, 255));
        if (c == r_acc[i])
          put(i, good, r_val[i]);
        else if (filt && i == 3 && (c == 1 || c == 2))
          put(i, good + 8'd1, {32'd5, 32'd0});
        else if (filt && i == 3 && c == 4)
          put(i, good, {32'd7, 32'd0});
        else if (noise && $urandom_range(0, 3) == 0) begin
          if (c > 0 && c < r_acc[i]) put(i, stale, {32'($urandom_range(0, 50)), 32'd0});
          else                       put(i, good,  {32'($urandom_range(0, 50)), 32'd0});
        end
      end
      @(posedge clk);
      #1;
    end
    lvt_valid = '0;
    if (mn >= m_gvt) m_gvt = mn;
    else             m_regress = 1'b1;
    e.gvt     = m_gvt;
    e.regress = m_regress;
    e.due     = req_cyc + amax + 1 + LAT;
    sb.push_back(e);
    nb = (req_cyc / PER + 1) * PER;
    exp_req = (nb <= e.due) ? e.due + 1 : nb;
    m_epoch = (m_epoch + 1) % 256;
  endtask

  task automatic round(input bit noise, input bit filt);
    if (!dead) wait_req();
    if (!dead) drive_round(noise, filt);
  endtask

  task automatic check_reset_outputs();
    check("rst_lvt_req", VW'(lvt_req), '0);
    check("rst_lvt_req_epoch", VW'(lvt_req_epoch), '0);
    check("rst_gvt_valid", VW'(gvt_valid), '0);
    check("rst_gvt", gvt, '0);
    check("rst_gvt_regress", VW'(gvt_regress), '0);
  endtask

  initial begin
    int n;
    gvt_enable = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rstn = 1'b1;

    for (int i = 0; i < NT; i++) begin
      r_acc[i] = 1 + i;
      r_val[i] = {32'(100 + i), 32'd0};
    end
    round(0, 0);

    for (int i = 0; i < NT; i++) begin
      r_acc[i] = $urandom_range(1, 10);
      r_val[i] = {32'd300, 32'd0};
    end
    r_acc[3] = 3;
    r_val[3] = {32'd200, 32'd0};
    round(0, 1);

    for (int i = 0; i < NT; i++) begin
      r_acc[i] = $urandom_range(1, 10);
      r_val[i] = {32'(250 + $urandom_range(0, 100)), 32'($urandom)};
    end
    r_val[$urandom_range(0, NT-1)] = {32'd150, 32'd0};
    round(1, 0);

    for (int i = 0; i < NT; i++) begin
      r_acc[i] = $urandom_range(1, 10);
      r_val[i] = {32'(400 + i), 32'd0};
    end
    r_acc[0] = 70;
    round(1, 0);

    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < NT; i++) begin
        r_acc[i] = $urandom_range(1, 20);
        r_val[i] = {32'(1000 + k*10 + $urandom_range(0, 50)), 32'($urandom)};
      end
      round(1, 0);
    end

    for (int i = 0; i < NT; i++) begin
      r_acc[i] = $urandom_range(1, 12);
      r_val[i] = VT_INFINITY;
    end
    round(1, 0);

    if (!dead) begin
      wait_req();
      if (!dead) begin
        for (int c = 1; c <= 5; c++) begin
          lvt_valid = '0;
          put(c - 1, EW'(m_epoch), {32'(20 + c), 32'd0});
          @(posedge clk);
          #1;
        end
        lvt_valid = '0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        for (int i = 0; i < NT; i++) begin
          r_acc[i] = $urandom_range(1, 15);
          r_val[i] = {32'(50 + $urandom_range(0, 1000)), 32'($urandom)};
        end
        round(0, 0);
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("scoreboard_drained", VW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
